twos_comp: RTL and testbench



---
 rtl/twos_comp_pkg.sv | 9 +
 rtl/twos_comp.sv | 53 +++++
 tb/tb_twos_comp.sv | 118 +++++++++++
 3 files changed

// File: rtl/twos_comp_pkg.sv
// Shared types for the bit-serial two's-complement converter.
package twos_comp_pkg;

  typedef enum logic {
    S_PASS = 1'b0,
    S_INV  = 1'b1
  } twos_comp_state_e;

endpackage

// File: rtl/twos_comp.sv
// Bit-serial two's-complement converter (LSB first); rstn also marks start-of-word.
// Define TWOS_COMP_REG_OUT_EN to register the output (one cycle of latency).
module twos_comp (
  input  logic clk,
  input  logic rstn,
  input  logic in,
  output logic out
);
  import twos_comp_pkg::*;

  // Serial handshake: none. A new bit is presented every cycle; there is no
  // valid/ready pair, words are delimited only by pulsing rstn.
  twos_comp_state_e state_q, state_d;
  logic             out_bit;

  always_comb begin
    state_d = state_q;
    out_bit = in;
    if (state_q == S_INV) begin
      out_bit = ~in;
    end else if (in) begin
      state_d = S_INV;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_PASS;
    else       state_q <= state_d;
  end

`ifdef TWOS_COMP_REG_OUT_EN
  logic out_d, out_q;

  assign out_d = out_bit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) out_q <= 1'b0;
    else       out_q <= out_d;
  end

  assign out = out_q;
`else
  // Gating with rstn keeps X on in or an uninitialised state off the output.
  assign out = rstn ? out_bit : 1'b0;
`endif

  a_inv_absorbing: assert property (@(posedge clk) disable iff (!rstn)
    (state_q == S_INV) |=> (state_q == S_INV));

  a_out_zero_in_reset: assert property (@(posedge clk)
    !rstn |-> (out == 1'b0));

endmodule

// File: tb/tb_twos_comp.sv
// Self-checking bench for twos_comp: directed words plus random words checked
// against an arithmetic model ((-word) mod 2^n).
module tb_twos_comp;

  logic clk;
  logic rstn;
  logic in;
  logic out;

  int n_cmp;
  int n_err;

  twos_comp dut (
    .clk  (clk),
    .rstn (rstn),
    .in   (in),
    .out  (out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Assert reset shortly after an edge, check out is 0 immediately and while
  // in is X, then release just after the next posedge.
  task automatic apply_reset(input string tag);
    rstn = 1'b0;
    in   = 1'bx;
    #1;
    check_val({tag, "_rst_now"}, {31'b0, out}, 32'd0);
    @(negedge clk);
    check_val({tag, "_rst_neg"}, {31'b0, out}, 32'd0);
    check_val({tag, "_rst_state"}, {31'b0, dut.state_q}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Drive an n-bit word LSB first; expected result is (-word) mod 2^n and the
  // state after k bits is S_INV exactly when the low k bits are nonzero.
  task automatic run_word(input string tag, input logic [31:0] word, input int n);
    logic [31:0] mask;
    logic [31:0] exp_w;
    logic [31:0] pre_mask;
    logic        exp_bit;
    logic        exp_st;
    mask  = (n >= 32) ? 32'hffff_ffff : ((32'd1 << n) - 32'd1);
    exp_w = (32'd0 - word) & mask;
    apply_reset(tag);
    for (int k = 0; k < n; k++) begin
      in = word[k];
      pre_mask = (32'd1 << k) - 32'd1;
      exp_st = ((word & pre_mask) != 32'd0);
      @(negedge clk);
      check_val({tag, "_state"}, {31'b0, dut.state_q}, {31'b0, exp_st});
`ifdef TWOS_COMP_REG_OUT_EN
      if (k > 0) begin
        exp_bit = exp_w[k-1];
        check_val({tag, "_out"}, {31'b0, out}, {31'b0, exp_bit});
      end
`else
      exp_bit = exp_w[k];
      check_val({tag, "_out"}, {31'b0, out}, {31'b0, exp_bit});
`endif
      @(posedge clk);
      #1;
    end
    in = 1'b0;
`ifdef TWOS_COMP_REG_OUT_EN
    @(negedge clk);
    exp_bit = exp_w[n-1];
    check_val({tag, "_out_last"}, {31'b0, out}, {31'b0, exp_bit});
`endif
    exp_st = ((word & mask) != 32'd0);
    check_val({tag, "_state_end"}, {31'b0, dut.state_q}, {31'b0, exp_st});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstn  = 1'b0;
    in    = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1,0,1,1,1,0 -> 1,1,0,0,0,1
    run_word("w29", 32'd29, 6);
    run_word("zero", 32'd0, 4);
    // 0,0,1,0,1 -> 0,0,1,1,0
    run_word("w20", 32'd20, 5);
    // -8 in 4 bits maps to itself
    run_word("mneg", 32'd8, 4);
    // partial word 1,1 cut by reset, then 0,1 restarts as a fresh word
    run_word("mid_a", 32'd3, 2);
    run_word("mid_b", 32'd2, 2);

    for (int t = 0; t < 40; t++) begin
      int          n;
      logic [31:0] w;
      n = $urandom_range(1, 16);
      w = $urandom & ((32'd1 << n) - 32'd1);
      if ($urandom_range(0, 3) == 0) w = w & ~((32'd1 << (n / 2)) - 32'd1);
      run_word("rnd", w, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
